// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage: occupancy-encoded state and
// performance counter width.
package pipe_pkg;

  localparam int CNT_W = 32;

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating event counter; cleared by reset, sticks at all-ones.
module pipe_sat_counter
  import pipe_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Two-entry skid-buffered pipeline register with registered handshakes.
// Define PIPE_STAGE_PERF_EN to enable the stall/bubble counters.
//
// state | meaning
// EMPTY | no entry held, main/skid at RESET_VALUE
// HALF  | one entry in main, skid at RESET_VALUE
// FULL  | head in main, second entry in skid, in_ready low
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  state_t           state;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             accept;
  logic             pop;

  assign accept = in_valid & in_ready_q;
  assign pop    = out_valid_q & out_ready;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state       <= EMPTY;
      main_q      <= RESET_VALUE;
      skid_q      <= RESET_VALUE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_q      <= in_data;
            state       <= HALF;
            out_valid_q <= 1'b1;
          end
        end
        HALF: begin
          if (accept && pop) begin
            main_q <= in_data;
          end else if (accept) begin
            skid_q     <= in_data;
            state      <= FULL;
            in_ready_q <= 1'b0;
          end else if (pop) begin
            main_q      <= RESET_VALUE;
            state       <= EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        FULL: begin
          if (pop) begin
            main_q     <= skid_q;
            skid_q     <= RESET_VALUE;
            state      <= HALF;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state       <= EMPTY;
          main_q      <= RESET_VALUE;
          skid_q      <= RESET_VALUE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign occupancy = state;

`ifdef PIPE_STAGE_PERF_EN
  pipe_sat_counter u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (out_valid_q & ~out_ready),
    .count (stall_cnt)
  );

  pipe_sat_counter u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (~out_valid_q & out_ready),
    .count (bubble_cnt)
  );
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter WIDTH, default 32, payload bit width (>=1).
REQ-002 Parameter RESET_VALUE, default 0 (WIDTH bits), payload value held by empty or flushed entries.
REQ-003 Port clk input 1, clock; all state SHALL update on rising edge only.
REQ-004 Port reset input 1, synchronous, active-high.
REQ-005 Port flush input 1, synchronous discard of all held entries (pipeline clear).
REQ-006 Port in_valid input 1, upstream offers in_data.
REQ-007 Port in_ready output 1, stage can accept; transfer occurs when in_valid & in_ready.
REQ-008 Port in_data input WIDTH, upstream payload.
REQ-009 Port out_valid output 1, out_data holds a valid entry.
REQ-010 Port out_ready input 1, downstream accepts; transfer occurs when out_valid & out_ready.
REQ-011 Port out_data output WIDTH, head entry payload.
REQ-012 Port occupancy output 2, held entry count (0..2).
REQ-013 Port stall_cnt output 32, cycles with out_valid & ~out_ready.
REQ-014 Port bubble_cnt output 32, cycles with ~out_valid & out_ready.

Function
REQ-015 Storage: main register plus one skid register; states EMPTY (0), HALF (1), FULL (2) SHALL equal occupancy.
REQ-016 in_ready SHALL be registered and equal (state != FULL); no combinational path from out_ready to in_ready.
REQ-017 out_valid SHALL be registered and equal (state != EMPTY); out_data SHALL come from the main register with no combinational path from in_data.
REQ-018 EMPTY: accept -> HALF, data in main; else stay.
REQ-019 HALF: accept & pop -> HALF, main loads in_data; accept only -> FULL, skid loads in_data; pop only -> EMPTY; neither -> stay.
REQ-020 FULL: pop -> HALF, main loads skid; no accept possible; else stay.
REQ-021 Latency: entry accepted in cycle N SHALL appear on out_data with out_valid in cycle N+1 when stage was EMPTY or HALF-with-pop.
REQ-022 Throughput: one transfer per cycle sustained when out_ready stays high.
REQ-023 Order SHALL be preserved; no entry duplicated or dropped except by flush.
REQ-024 While out_valid & ~out_ready, out_data SHALL stay stable.
REQ-025 flush SHALL next cycle force EMPTY, both registers to RESET_VALUE, in_ready=1; an accept or pop in the flush cycle is discarded/ignored (flush has priority).
REQ-026 Empty entries SHALL always hold RESET_VALUE (out_data=RESET_VALUE when out_valid=0).
REQ-027 Counters SHALL saturate at 32'hFFFF_FFFF and are NOT cleared by flush.

Reset
REQ-028 reset SHALL override flush and all transfers: state EMPTY, in_ready=1, out_valid=0, out_data=RESET_VALUE, occupancy=0, stall_cnt=0, bubble_cnt=0.
REQ-029 reset asserted mid-operation SHALL drop all held entries in that cycle; in_ready=1 in the first cycle after release.

Configuration
REQ-030 Macro PIPE_STAGE_PERF_EN: defined -> stall_cnt/bubble_cnt count per REQ-013/014/027; undefined -> counter logic removed, ports remain and are tied to 0.

Structure
REQ-031 Shared package pipe_pkg SHALL hold the state encoding typedef (EMPTY/HALF/FULL) and the counter width constant (32).
REQ-032 Single sub-module pipe_sat_counter (saturating 32-bit increment/clear), instantiated twice under PIPE_STAGE_PERF_EN.

Verification
REQ-033 Stream 0x11,0x22,0x33 with out_ready=1 -> out_data 0x11,0x22,0x33 in consecutive cycles, each 1 cycle after accept, occupancy stays <=1.
REQ-034 Push 0xA,0xB with out_ready=0 -> occupancy 2, in_ready=0, out_data=0xA stable; raise out_ready -> 0xA then 0xB, in_ready=1 one cycle after first pop.
REQ-035 FULL (0xA,0xB) plus flush with in_valid=1 in_data=0xC -> next cycle occupancy 0, out_valid=0, out_data=RESET_VALUE, 0xC never emitted.
REQ-036 reset asserted while FULL and flush=1 -> all outputs at reset values next cycle, counters 0.
REQ-037 With PIPE_STAGE_PERF_EN: 5 cycles out_valid=1/out_ready=0 then 3 cycles empty with out_ready=1 -> stall_cnt=5, bubble_cnt=3; flush leaves both unchanged; without macro both read 0.
REQ-038 Random valid/ready (10k cycles, WIDTH=8 and 64) against FIFO scoreboard -> zero mismatches, no loss or reorder, out_data stable whenever out_valid & ~out_ready.
